// File: rtl/writeback_arbiter_if.sv
// Register-file writeback bundle: ALU and load producers in, write port, busy and bypass out.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline's.
interface writeback_arbiter_if #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 4
);
    localparam int REG_AW = $clog2(REG_CNT);

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;

    logic              ld_valid;
    logic              ld_ready;
    logic [REG_AW-1:0] ld_reg;
    logic [DATA_W-1:0] ld_data;

    logic              write_en;
    logic [REG_AW-1:0] write_reg;
    logic [DATA_W-1:0] write_value;

    logic [REG_CNT-1:0] busy;

    logic [REG_AW-1:0] byp_reg;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  ld_valid, ld_reg, ld_data,
        input  byp_reg,
        output alu_ready, ld_ready,
        output write_en, write_reg, write_value,
        output busy, byp_hit, byp_data
    );

    modport master (
        output alu_valid, alu_reg, alu_data,
        output ld_valid, ld_reg, ld_data,
        output byp_reg,
        input  alu_ready, ld_ready,
        input  write_en, write_reg, write_value,
        input  busy, byp_hit, byp_data
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin merge of ALU results and queued load results onto the single register-file write port.
// Define WB_BYPASS_EN to expose the in-flight write on byp_hit/byp_data; otherwise they are tied to 0.
module writeback_arbiter #(
    parameter int DATA_W   = 8,
    parameter int REG_CNT  = 4,
    parameter int LQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    writeback_arbiter_if.slave bus
);
    localparam int REG_AW = $clog2(REG_CNT);
    localparam int PTR_W  = $clog2(LQ_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {
        GRANT_ALU  = 1'b0,
        GRANT_LOAD = 1'b1
    } grant_e;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] value;
    } wb_entry_t;

    wb_entry_t         lq_mem [LQ_DEPTH];
    logic [PTR_W-1:0]  lq_head;
    logic [PTR_W-1:0]  lq_tail;
    logic [CNT_W-1:0]  lq_count;
    grant_e            last_grant;

    logic              write_en_q;
    logic [REG_AW-1:0] write_reg_q;
    logic [DATA_W-1:0] write_value_q;

    logic              lq_empty;
    logic              lq_full;
    logic              enq;
    logic              contention;
    logic              alu_win;
    logic              ld_win;
    wb_entry_t         lq_head_entry;
    logic [REG_CNT-1:0] busy_vec;

    assign lq_empty      = (lq_count == '0);
    assign lq_full       = (lq_count == CNT_W'(LQ_DEPTH));
    assign enq           = bus.ld_valid && !lq_full;
    assign lq_head_entry = lq_mem[lq_head];

    // Without contention the lone candidate wins; with it, the source that lost last time goes.
    assign contention = bus.alu_valid && !lq_empty;
    assign alu_win    = bus.alu_valid && (lq_empty || last_grant == GRANT_LOAD);
    assign ld_win     = !lq_empty && !alu_win;

    assign bus.alu_ready = alu_win;
    assign bus.ld_ready  = !lq_full;

    // NOTE: every clocked assignment uses <= so all registers sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lq_head       <= '0;
            lq_tail       <= '0;
            lq_count      <= '0;
            last_grant    <= GRANT_LOAD;
            write_en_q    <= 1'b0;
            write_reg_q   <= '0;
            write_value_q <= '0;
        end else begin
            if (enq) begin
                lq_tail <= lq_tail + PTR_W'(1);
            end
            if (ld_win) begin
                lq_head <= lq_head + PTR_W'(1);
            end
            case ({enq, ld_win})
                2'b10:   lq_count <= lq_count + CNT_W'(1);
                2'b01:   lq_count <= lq_count - CNT_W'(1);
                default: lq_count <= lq_count;
            endcase

            if (contention) begin
                last_grant <= alu_win ? GRANT_ALU : GRANT_LOAD;
            end

            if (alu_win) begin
                write_en_q    <= 1'b1;
                write_reg_q   <= bus.alu_reg;
                write_value_q <= bus.alu_data;
            end else if (ld_win) begin
                write_en_q    <= 1'b1;
                write_reg_q   <= lq_head_entry.dest;
                write_value_q <= lq_head_entry.value;
            end else begin
                write_en_q    <= 1'b0;
            end
        end
    end

    // NOTE: queue storage is not reset; an entry is only ever read while lq_count marks it valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            lq_mem[lq_tail] <= '{dest: bus.ld_reg, value: bus.ld_data};
        end
    end

    // NOTE: busy_vec gets a full default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset = PTR_W'(i) - lq_head;
            if ({1'b0, offset} < lq_count) begin
                busy_vec[lq_mem[i].dest] = 1'b1;
            end
        end
        if (write_en_q) begin
            busy_vec[write_reg_q] = 1'b1;
        end
    end

    assign bus.busy        = busy_vec;
    assign bus.write_en    = write_en_q;
    assign bus.write_reg   = write_reg_q;
    assign bus.write_value = write_value_q;

`ifdef WB_BYPASS_EN
    logic byp_match;
    assign byp_match    = write_en_q && (write_reg_q == bus.byp_reg);
    assign bus.byp_hit  = byp_match;
    assign bus.byp_data = byp_match ? write_value_q : '0;
`else
    logic unused_byp_reg;
    assign unused_byp_reg = ^bus.byp_reg;
    assign bus.byp_hit    = 1'b0;
    assign bus.byp_data   = '0;
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        lq_count <= CNT_W'(LQ_DEPTH));

    a_single_grant: assert property (@(posedge clk) disable iff (!reset)
        !(alu_win && ld_win));
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed vector table plus randomized traffic checked against a queue-based reference model.
module tb_writeback_arbiter;
    localparam int DATA_W   = 8;
    localparam int REG_CNT  = 4;
    localparam int LQ_DEPTH = 2;
    localparam int N_RAND   = 3000;
`ifdef WB_BYPASS_EN
    localparam bit BYP_EN = 1'b1;
`else
    localparam bit BYP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) bus ();

    writeback_arbiter #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT),
        .LQ_DEPTH(LQ_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic       av;
        logic [1:0] ar;
        logic [7:0] ad;
        logic       lv;
        logic [1:0] lr;
        logic [7:0] ld;
        logic [1:0] br;
        logic       e_ar;
        logic       e_lr;
        logic       e_we;
        logic [1:0] e_wr;
        logic [7:0] e_wv;
        logic [3:0] e_busy;
        logic       e_bh;
        logic [7:0] e_bd;
    } vec_t;

    typedef struct {
        logic [1:0] dest;
        logic [7:0] value;
    } ent_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_ar, input logic e_lr, input logic e_we,
                             input logic [1:0] e_wr, input logic [7:0] e_wv, input logic [3:0] e_busy,
                             input logic e_bh, input logic [7:0] e_bd);
        logic       x_bh;
        logic [7:0] x_bd;
        x_bh = BYP_EN ? e_bh : 1'b0;
        x_bd = BYP_EN ? e_bd : 8'h00;
        check({tag, ".alu_ready"},   32'(bus.alu_ready),   32'(e_ar));
        check({tag, ".ld_ready"},    32'(bus.ld_ready),    32'(e_lr));
        check({tag, ".write_en"},    32'(bus.write_en),    32'(e_we));
        check({tag, ".write_reg"},   32'(bus.write_reg),   32'(e_wr));
        check({tag, ".write_value"}, 32'(bus.write_value), 32'(e_wv));
        check({tag, ".busy"},        32'(bus.busy),        32'(e_busy));
        check({tag, ".byp_hit"},     32'(bus.byp_hit),     32'(x_bh));
        check({tag, ".byp_data"},    32'(bus.byp_data),    32'(x_bd));
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        bus.alu_valid = v.av;
        bus.alu_reg   = v.ar;
        bus.alu_data  = v.ad;
        bus.ld_valid  = v.lv;
        bus.ld_reg    = v.lr;
        bus.ld_data   = v.ld;
        bus.byp_reg   = v.br;
    endtask

    function automatic vec_t row(input logic rst, input logic av, input logic [1:0] ar, input logic [7:0] ad,
                                 input logic lv, input logic [1:0] lr, input logic [7:0] ld, input logic [1:0] br,
                                 input logic e_ar, input logic e_lr, input logic e_we, input logic [1:0] e_wr,
                                 input logic [7:0] e_wv, input logic [3:0] e_busy, input logic e_bh,
                                 input logic [7:0] e_bd);
        vec_t v;
        v.rst = rst;   v.av = av;     v.ar = ar;     v.ad = ad;
        v.lv = lv;     v.lr = lr;     v.ld = ld;     v.br = br;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_we = e_we; v.e_wr = e_wr;
        v.e_wv = e_wv; v.e_busy = e_busy; v.e_bh = e_bh; v.e_bd = e_bd;
        return v;
    endfunction

    // Reference model state: queued loads, output stage, and which source wins the next contention.
    ent_t       mq[$];
    logic       m_we;
    logic [1:0] m_wr;
    logic [7:0] m_wv;
    bit         m_alu_first;

    task automatic model_reset();
        mq.delete();
        m_we        = 1'b0;
        m_wr        = '0;
        m_wv        = '0;
        m_alu_first = 1'b1;
    endtask

    initial begin
        vec_t idle;
        idle = row(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 2'd0,
                   1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 8'h00);

        //            rst av ar  ad     lv lr  ld     br   ar lr we wr  wv     busy     bh bd
        tbl.push_back(row(0, 1, 2, 8'hA5, 1, 1, 8'h11, 0,  1, 1, 0, 0, 8'h00, 4'b0000, 0, 8'h00));
        tbl.push_back(row(0, 1, 2, 8'hA5, 1, 1, 8'h11, 0,  1, 1, 0, 0, 8'h00, 4'b0000, 0, 8'h00));
        tbl.push_back(row(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, 4'b0000, 0, 8'h00));
        tbl.push_back(row(1, 1, 2, 8'hA5, 0, 0, 8'h00, 0,  1, 1, 0, 0, 8'h00, 4'b0000, 0, 8'h00));
        tbl.push_back(row(1, 0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 1, 1, 2, 8'hA5, 4'b0100, 0, 8'h00));
        tbl.push_back(row(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 0, 2, 8'hA5, 4'b0000, 0, 8'h00));
        // Loads r1:11, r3:33, r0:44 against an ALU that is valid every cycle
        tbl.push_back(row(1, 1, 0, 8'h01, 1, 1, 8'h11, 0,  1, 1, 0, 2, 8'hA5, 4'b0000, 0, 8'h00));
        tbl.push_back(row(1, 1, 0, 8'h02, 1, 3, 8'h33, 0,  1, 1, 1, 0, 8'h01, 4'b0011, 1, 8'h01));
        tbl.push_back(row(1, 1, 0, 8'h03, 1, 0, 8'h44, 0,  0, 0, 1, 0, 8'h02, 4'b1011, 1, 8'h02));
        tbl.push_back(row(1, 1, 0, 8'h03, 1, 0, 8'h44, 0,  1, 1, 1, 1, 8'h11, 4'b1010, 0, 8'h00));
        tbl.push_back(row(1, 1, 0, 8'h04, 0, 0, 8'h00, 0,  0, 0, 1, 0, 8'h03, 4'b1001, 1, 8'h03));
        tbl.push_back(row(1, 1, 0, 8'h04, 0, 0, 8'h00, 0,  1, 1, 1, 3, 8'h33, 4'b1001, 0, 8'h00));
        tbl.push_back(row(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 1, 0, 8'h04, 4'b0001, 1, 8'h04));
        tbl.push_back(row(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 1, 0, 8'h44, 4'b0001, 1, 8'h44));
        tbl.push_back(row(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h44, 4'b0000, 0, 8'h00));
        // Fill the queue with two entries, then reset for one edge
        tbl.push_back(row(1, 1, 1, 8'hA1, 1, 2, 8'h55, 0,  1, 1, 0, 0, 8'h44, 4'b0000, 0, 8'h00));
        tbl.push_back(row(1, 1, 1, 8'hA2, 1, 3, 8'h66, 0,  0, 1, 1, 1, 8'hA1, 4'b0110, 0, 8'h00));
        tbl.push_back(row(1, 1, 1, 8'hA2, 1, 0, 8'h77, 0,  1, 1, 1, 2, 8'h55, 4'b1100, 0, 8'h00));
        tbl.push_back(row(0, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 1, 1, 8'hA2, 4'b1011, 0, 8'h00));
        tbl.push_back(row(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, 4'b0000, 0, 8'h00));
        tbl.push_back(row(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, 4'b0000, 0, 8'h00));
        // First contention after reset goes to the ALU; bypass hit on r3 and r1
        tbl.push_back(row(1, 1, 3, 8'h5C, 1, 2, 8'h88, 0,  1, 1, 0, 0, 8'h00, 4'b0000, 0, 8'h00));
        tbl.push_back(row(1, 1, 1, 8'hBB, 0, 0, 8'h00, 3,  1, 1, 1, 3, 8'h5C, 4'b1100, 1, 8'h5C));
        tbl.push_back(row(1, 0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 1, 1, 1, 8'hBB, 4'b0110, 1, 8'hBB));
        tbl.push_back(row(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 1, 2, 8'h88, 4'b0100, 0, 8'h00));
        tbl.push_back(row(1, 0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 1, 0, 2, 8'h88, 4'b0000, 0, 8'h00));

        drive(idle);
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].e_ar, tbl[i].e_lr, tbl[i].e_we, tbl[i].e_wr,
                      tbl[i].e_wv, tbl[i].e_busy, tbl[i].e_bh, tbl[i].e_bd);
        end

        @(negedge clk);
        drive(idle);
        model_reset();

        begin
            vec_t       s;
            bit         alu_pend;
            bit         alu_wins;
            bit         contended;
            logic       e_lr;
            logic       e_bh;
            logic [7:0] e_bd;
            logic [3:0] e_busy;
            ent_t       e;
            alu_pend = 1'b0;
            s = idle;
            for (int i = 0; i < N_RAND; i++) begin
                @(negedge clk);
                s.rst = ($urandom_range(0, 63) != 0);
                if (!alu_pend) begin
                    s.av = ($urandom_range(0, 2) != 0);
                    s.ar = 2'($urandom_range(0, 3));
                    s.ad = 8'($urandom_range(0, 255));
                end
                s.lv = ($urandom_range(0, 1) != 0);
                s.lr = 2'($urandom_range(0, 3));
                s.ld = 8'($urandom_range(0, 255));
                s.br = 2'($urandom_range(0, 3));
                drive(s);
                #1;

                e_lr     = (mq.size() < LQ_DEPTH);
                alu_wins = s.av && (mq.size() == 0 || m_alu_first);
                e_busy   = '0;
                foreach (mq[k]) e_busy[mq[k].dest] = 1'b1;
                if (m_we) e_busy[m_wr] = 1'b1;
                e_bh = m_we && (m_wr == s.br);
                e_bd = e_bh ? m_wv : 8'h00;
                check_all($sformatf("rand%0d", i), alu_wins, e_lr, m_we, m_wr, m_wv, e_busy, e_bh, e_bd);

                if (!s.rst) begin
                    model_reset();
                    alu_pend = 1'b0;
                end else begin
                    contended = s.av && (mq.size() > 0);
                    if (alu_wins) begin
                        m_we = 1'b1; m_wr = s.ar; m_wv = s.ad;
                    end else if (mq.size() > 0) begin
                        e = mq.pop_front();
                        m_we = 1'b1; m_wr = e.dest; m_wv = e.value;
                    end else begin
                        m_we = 1'b0;
                    end
                    if (contended) m_alu_first = !alu_wins;
                    if (s.lv && e_lr) mq.push_back('{dest: s.lr, value: s.ld});
                    alu_pend = s.av && !alu_wins;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
